// File: rtl/ac_sched_if.sv
// Bundle of requester, accumulator and result signals around the ac_sched arbiter.
// slave is the scheduler side; master is the environment (sources, accumulator, sink).
interface ac_sched_if #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAX_LEN = 16
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = $clog2(NREQ);

    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] req_len;
    logic [NREQ-1:0]    gnt;
    logic [NREQ*8-1:0]  in_data;
    logic [NREQ-1:0]    in_valid;
    logic [NREQ-1:0]    in_ready;
    logic               acc_clr;
    logic [7:0]         acc_in;
    logic [15:0]        acc_sum;
    logic               res_valid;
    logic [IW-1:0]      res_id;
    logic [15:0]        res_sum;
    logic               busy;

    modport slave (
        input  req, req_len, in_data, in_valid, acc_sum,
        output gnt, in_ready, acc_clr, acc_in, res_valid, res_id, res_sum, busy
    );

    modport master (
        output req, req_len, in_data, in_valid, acc_sum,
        input  gnt, in_ready, acc_clr, acc_in, res_valid, res_id, res_sum, busy
    );
endinterface

// File: rtl/ac_sched.sv
// Round-robin scheduler sharing one 8-bit-in / 16-bit-sum accumulator among NREQ
// requesters: grant, clear, stream one burst (bubbles zero-filled), report the sum.
module ac_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MAX_LEN = 16
) (
    input logic       clk,
    input logic       rst,
    ac_sched_if.slave bus
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);
    localparam int unsigned IW = $clog2(NREQ);

    typedef enum logic [2:0] {StIdle, StClear, StStream, StDrain, StDone} state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   last_owner_q, last_owner_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic            drain_q, drain_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            acc_clr_q, acc_clr_d;
    logic [7:0]      acc_in_q, acc_in_d;
    logic            res_valid_q, res_valid_d;
    logic [IW-1:0]   res_id_q, res_id_d;
    logic [15:0]     res_sum_q, res_sum_d;

    logic [LW-1:0]   len_arr [NREQ];
    logic [7:0]      data_arr [NREQ];
    logic            win_found;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   cand;
    logic [LW-1:0]   len_clamped;
    logic [NREQ-1:0] ready;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            len_arr[i]  = bus.req_len[i*LW +: LW];
            data_arr[i] = bus.in_data[i*8 +: 8];
        end
    end

    // Search starts just after the last served requester so everyone gets a turn.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            cand = IW'((int'(last_owner_q) + i) % int'(NREQ));
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign len_clamped = (len_arr[win_idx] > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len_arr[win_idx];

    always_comb begin
        ready = '0;
        if (state_q == StStream) begin
            ready[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        rem_d        = rem_q;
        drain_d      = 1'b0;
        gnt_d        = '0;
        acc_clr_d    = 1'b0;
        acc_in_d     = '0;
        res_valid_d  = 1'b0;
        res_id_d     = res_id_q;
        res_sum_d    = res_sum_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    owner_d        = win_idx;
                    rem_d          = len_clamped;
                    gnt_d[win_idx] = 1'b1;
                    acc_clr_d      = 1'b1;
                    state_d        = StClear;
                end
            end
            StClear: state_d = (rem_q != '0) ? StStream : StDrain;
            StStream: begin
                if (bus.in_valid[owner_q]) begin
                    acc_in_d = data_arr[owner_q];
                    rem_d    = rem_q - LW'(1);
                    if (rem_q == LW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // Two cycles let the last addend land in acc_sum before it is captured.
                drain_d = 1'b1;
                if (drain_q) begin
                    res_valid_d  = 1'b1;
                    res_id_d     = owner_q;
                    res_sum_d    = bus.acc_sum;
                    last_owner_d = owner_q;
                    state_d      = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_owner_q <= IW'(NREQ - 1);
            rem_q        <= '0;
            drain_q      <= 1'b0;
            gnt_q        <= '0;
            acc_clr_q    <= 1'b1;
            acc_in_q     <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
            res_sum_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            rem_q        <= rem_d;
            drain_q      <= drain_d;
            gnt_q        <= gnt_d;
            acc_clr_q    <= acc_clr_d;
            acc_in_q     <= acc_in_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
            res_sum_q    <= res_sum_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.in_ready  = ready;
    assign bus.acc_clr   = acc_clr_q;
    assign bus.acc_in    = acc_in_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_ac_sched.sv
// Scoreboard bench for ac_sched: directed bursts push expected {id, sum, latency};
// a monitor pops and compares on every res_valid.
module tb_ac_sched;
    localparam int NREQ    = 4;
    localparam int MAX_LEN = 16;
    localparam int LW      = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ac_sched_if #(.NREQ(NREQ), .MAX_LEN(MAX_LEN)) bus ();

    ac_sched #(.NREQ(NREQ), .MAX_LEN(MAX_LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Behavioural accumulator the scheduler drives.
    logic [15:0] acc_model = '0;
    always @(posedge clk) begin
        if (bus.acc_clr) acc_model <= '0;
        else             acc_model <= acc_model + 16'(bus.acc_in);
    end
    assign bus.acc_sum = acc_model;

    typedef struct {
        int id;
        int sum;
        int lat;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          checks = 0;
    int          passed = 0;
    int          cyc = 0;
    int          gnt_cyc = 0;
    int          owner_seen = 0;
    int          ready_viol = 0;
    int          gnt_viol = 0;
    logic [7:0]  samp [32];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic expect_res(input int id, input int sum, input int lat);
        exp_t e;
        e.id  = id;
        e.sum = sum;
        e.lat = lat;
        sb.push_back(e);
    endtask

    // Monitor: grant/ready protocol bookkeeping and result scoreboard.
    initial begin
        exp_t            e;
        logic [NREQ-1:0] gnt_prev = '0;
        logic [NREQ-1:0] one = 1;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (bus.gnt != '0) begin
                    if (!$onehot(bus.gnt) || gnt_prev != '0) gnt_viol++;
                    for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) owner_seen = i;
                    gnt_cyc = cyc;
                    grant_log.push_back(owner_seen);
                end
                if ((bus.in_ready & ~(one << owner_seen)) != '0) ready_viol++;
                if (bus.res_valid) begin
                    if (sb.size() == 0) begin
                        check("res_expected_pending", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        check("res_id", int'(bus.res_id), e.id);
                        check("res_sum", int'(bus.res_sum), e.sum);
                        check("res_latency", cyc - gnt_cyc, e.lat);
                    end
                end
            end
            gnt_prev = bus.gnt;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"}, int'(bus.gnt), 0);
        check({tag, "_in_ready"}, int'(bus.in_ready), 0);
        check({tag, "_acc_clr"}, int'(bus.acc_clr), 1);
        check({tag, "_acc_in"}, int'(bus.acc_in), 0);
        check({tag, "_res_valid"}, int'(bus.res_valid), 0);
        check({tag, "_res_id"}, int'(bus.res_id), 0);
        check({tag, "_res_sum"}, int'(bus.res_sum), 0);
        check({tag, "_busy"}, int'(bus.busy), 0);
    endtask

    // Called on a negedge; returns on the negedge where gnt[id] is seen.
    task automatic start_burst(input int id, input int len);
        int n = 0;
        bus.req_len[id*LW +: LW] = LW'(len);
        bus.req[id] = 1'b1;
        while (!bus.gnt[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("gnt_seen_id%0d", id), int'(bus.gnt[id]), 1);
        bus.req[id] = 1'b0;
    endtask

    task automatic feed(input int id, input int n, input int stall_at, input int stall_n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            bus.in_data[id*8 +: 8] = samp[i];
            bus.in_valid[id] = 1'b1;
            while (!bus.in_ready[id] && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) check($sformatf("in_ready_id%0d", id), int'(bus.in_ready[id]), 1);
            @(negedge clk);
            bus.in_valid[id] = 1'b0;
            if (i == stall_at) repeat (stall_n) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((sb.size() != 0 || bus.busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drained"}, sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int g;
        int n;
        int base;
        bus.req      = '0;
        bus.req_len  = '0;
        bus.in_data  = '0;
        bus.in_valid = '0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b1;
        @(negedge clk);
        check("release_acc_clr", int'(bus.acc_clr), 0);
        check("release_busy", int'(bus.busy), 0);

        // Single burst, no stalls: 10+20+30+40, gnt->res_valid = 4+3.
        samp[0] = 8'd10; samp[1] = 8'd20; samp[2] = 8'd30; samp[3] = 8'd40;
        expect_res(2, 100, 7);
        start_burst(2, 4);
        feed(2, 4, -1, 0);
        wait_done("single");

        // Two bubble cycles after the first sample: 3*255, latency 3+3+2.
        for (int i = 0; i < 3; i++) samp[i] = 8'd255;
        expect_res(3, 765, 8);
        start_burst(3, 3);
        feed(3, 3, 0, 2);
        wait_done("stall");

        // Fairness: all four held high, two samples of 1 each, five grants.
        for (int k = 0; k < 5; k++) expect_res(k % 4, 2, 5);
        for (int i = 0; i < NREQ; i++) bus.req_len[i*LW +: LW] = LW'(2);
        bus.in_data  = {NREQ{8'd1}};
        bus.in_valid = '1;
        base = grant_log.size();
        bus.req = '1;
        g = 0;
        n = 0;
        while (g < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.gnt != '0) g++;
        end
        bus.req = '0;
        check("fair_grant_count", g, 5);
        wait_done("fair");
        bus.in_valid = '0;
        check("fair_log_len", grant_log.size() - base, 5);
        for (int k = 0; k < 5 && k < grant_log.size() - base; k++)
            check($sformatf("fair_order%0d", k), grant_log[base + k], k % 4);

        // Clamp: req_len=31 must stop after 16 samples; prior sum must be cleared.
        for (int i = 0; i < 16; i++) samp[i] = 8'd255;
        expect_res(1, 4080, 19);
        start_burst(1, 31);
        feed(1, 16, -1, 0);
        wait_done("max");

        // Zero length after a large sum.
        expect_res(2, 0, 3);
        start_burst(2, 0);
        wait_done("len0");

        // Abort mid-stream: no result may appear.
        for (int i = 0; i < 5; i++) samp[i] = 8'd7;
        start_burst(1, 5);
        feed(1, 2, -1, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        samp[0] = 8'd1; samp[1] = 8'd2; samp[2] = 8'd3;
        expect_res(3, 6, 6);
        start_burst(3, 3);
        feed(3, 3, -1, 0);
        wait_done("post_reset");

        repeat (5) @(negedge clk);
        check("in_ready_non_owner", ready_viol, 0);
        check("gnt_pulse_onehot", gnt_viol, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", passed, checks);
        $fatal(1);
    end
endmodule
